// File: rtl/popcount_seq_ctrl.sv
// Counts the 1s in a WORD_W-bit word one byte slice per cycle through a shared ones-counter.
// Latency: k edges from accept to out_valid (k = slices processed; early exit on an all-zero remainder).
// Backpressure: accepts only in IDLE; the result is held in DONE until out_ready.
module popcount_seq_ctrl #(
    parameter int WORD_W     = 32,
    parameter bit EARLY_EXIT = 1'b1,
    localparam int CNT_W     = $clog2(WORD_W + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_data,
    output logic [7:0]        cnt_x,
    input  logic [3:0]        cnt_o,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  out_count,
    output logic              busy
);

    localparam int NSLICE = WORD_W / 8;
    localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_COUNT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t             state;
    logic [WORD_W-1:0]  shift_reg;
    logic [CNT_W-1:0]   acc;
    logic [IDX_W-1:0]   idx;

    logic [WORD_W-1:0]  rest;
    logic [CNT_W-1:0]   slice_sum;
    logic               finish;

    assign rest      = shift_reg >> 8;
    assign slice_sum = acc + CNT_W'(cnt_o);
    // Early exit once every slice still waiting in the shift register is zero.
    assign finish    = (idx == LAST_IDX) || (EARLY_EXIT && (rest == '0));

    assign in_ready = (state == S_IDLE) && !rst;
    assign cnt_x    = (state == S_COUNT) ? shift_reg[7:0] : 8'h00;
    assign busy     = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            shift_reg <= '0;
            acc       <= '0;
            idx       <= '0;
            out_valid <= 1'b0;
            out_count <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid && in_ready) begin
                        shift_reg <= in_data;
                        acc       <= '0;
                        idx       <= '0;
                        state     <= S_COUNT;
                    end
                end
                S_COUNT: begin
                    acc       <= slice_sum;
                    shift_reg <= rest;
                    idx       <= idx + 1'b1;
                    if (finish) begin
                        out_count <= slice_sum;
                        out_valid <= 1'b1;
                        state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule
